// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int LEN_BYTES   = 4;
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed, XOR-checksummed byte stream, writes the payload
// into byte-addressed instruction memory and releases the CPU once the image verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 4096,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              we_o,
  output logic [WIDTH-1:0]  wa_o,
  output logic [DATA_W-1:0] wd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_run_o
);

  localparam int CNT_W = $clog2(MEM_DEPTH + 1);
  localparam int LEN_W = LEN_BYTES * DATA_W;
  localparam int AL_W  = $clog2(INSTR_BYTES);

  loader_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] csum;

  logic              acc;
  logic [LEN_W-1:0]  len_next;
  logic              last_len;
  logic              last_data;

  assign s_ready_o = (state == LEN) || (state == DATA) || (state == CSUM);
  assign busy_o    = s_ready_o;
  assign cpu_run_o = done_o;
  assign acc       = s_valid_i && s_ready_o;

  // Length arrives MSB first, so each byte shifts in from the bottom.
  assign len_next  = {len[LEN_W-DATA_W-1:0], s_data_i};
  assign last_len  = (cnt == CNT_W'(LEN_BYTES - 1));
  assign last_data = (LEN_W'(cnt) == len - LEN_W'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= '0;
      csum   <= '0;
      we_o   <= 1'b0;
      wa_o   <= '0;
      wd_o   <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      we_o <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state  <= LEN;
            cnt    <= '0;
            len    <= '0;
            csum   <= '0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
          end
        end
        LEN: begin
          if (acc) begin
            len <= len_next;
            cnt <= cnt + 1'b1;
            if (last_len) begin
              cnt <= '0;
              if (len_next > LEN_W'(MEM_DEPTH) || len_next[AL_W-1:0] != '0) begin
                state <= ERR;
                err_o <= 1'b1;
              end else if (len_next == '0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (acc) begin
            we_o <= 1'b1;
            wa_o <= WIDTH'(BASE_ADDR) + WIDTH'(cnt);
            wd_o <= s_data_i;
            csum <= csum ^ s_data_i;
            cnt  <= cnt + 1'b1;
            if (last_data) state <= CSUM;
          end
        end
        CSUM: begin
          if (acc) begin
            if (s_data_i == csum) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= ERR;
              err_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboard of expected memory writes plus per-scenario tasks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        we;
  logic [31:0] wa;
  logic [7:0]  wd;
  logic        busy, done, err, cpu_run;

  int errors = 0;
  int checks = 0;

  logic        payload_flag = 1'b0;
  logic        acc_payload = 1'b0;
  logic [39:0] exp_q[$];
  int          k = 0;

  logic [7:0] pl [8];
  logic [7:0] good_len [4];

  imem_loader dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .we_o(we), .wa_o(wa), .wd_o(wd),
    .busy_o(busy), .done_o(done), .err_o(err), .cpu_run_o(cpu_run)
  );

  always #5 clk = ~clk;

  // A write is expected exactly one cycle after each accepted payload byte.
  always @(posedge clk) acc_payload <= rst_n && s_valid && s_ready && payload_flag;

  always @(negedge clk) begin
    checks++;
    if (we !== acc_payload) begin
      errors++;
      $display("FAIL we_timing t=%0t got we=%b want %b", $time, we, acc_payload);
    end
    if (we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got wa=%0h wd=%0h want none", wa, wd);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({wa, wd} !== e) begin
          errors++;
          $display("FAIL write got wa=%0h wd=%0h want wa=%0h wd=%0h", wa, wd, e[39:8], e[7:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic is_pl, input logic gap);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = b;
    payload_flag = is_pl;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        if (is_pl) begin
          exp_q.push_back({32'(k), b});
          k++;
        end
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout got s_ready=%b want 1", s_ready);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    payload_flag = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    checks++;
    if ({busy, done, err, cpu_run} !== 4'b1000) begin
      errors++;
      $display("FAIL start_state got busy/done/err/run=%b want 1000", {busy, done, err, cpu_run});
    end
  endtask

  task automatic send_frame(input logic [7:0] csum, input logic gap);
    for (int i = 0; i < 4; i++) send(good_len[i], 1'b0, gap);
    for (int i = 0; i < 8; i++) send(pl[i], 1'b1, gap);
    send(csum, 1'b0, gap);
  endtask

  task automatic check_final(input string name, input logic exp_done, input logic exp_err);
    checks++;
    if ({done, cpu_run, err, busy, s_ready} !== {exp_done, exp_done, exp_err, 2'b00}) begin
      errors++;
      $display("FAIL %s got done/run/err/busy/rdy=%b want %b", name,
               {done, cpu_run, err, busy, s_ready}, {exp_done, exp_done, exp_err, 2'b00});
    end
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, we, done, err, cpu_run, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset got rdy/we/done/err/run/busy=%b want 000000",
               {s_ready, we, done, err, cpu_run, busy});
    end
    s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    do_start();
    send_frame(8'h90, 1'b0);
    check_final("nominal", 1'b1, 1'b0);
    check_drained("nominal");
  endtask

  task automatic test_gapped();
    do_start();
    send_frame(8'h90, 1'b1);
    check_final("gapped", 1'b1, 1'b0);
    check_drained("gapped");
  endtask

  task automatic test_bad_csum();
    do_start();
    send_frame(8'h91, 1'b0);
    check_final("bad_csum", 1'b0, 1'b1);
    check_drained("bad_csum");
    do_start();
    send_frame(8'h90, 1'b0);
    check_final("bad_csum_reload", 1'b1, 1'b0);
    check_drained("bad_csum_reload");
  endtask

  task automatic test_bad_len();
    logic [7:0] a [4];
    logic [7:0] b [4];
    a = '{8'h00, 8'h00, 8'h00, 8'h06};
    b = '{8'h00, 8'h00, 8'h10, 8'h04};
    do_start();
    for (int i = 0; i < 4; i++) send(a[i], 1'b0, 1'b0);
    check_final("len_unaligned", 1'b0, 1'b1);
    check_drained("len_unaligned");
    do_start();
    for (int i = 0; i < 4; i++) send(b[i], 1'b0, 1'b0);
    check_final("len_too_big", 1'b0, 1'b1);
    check_drained("len_too_big");
    do_start();
    for (int i = 0; i < 4; i++) send(8'h00, 1'b0, 1'b0);
    checks++;
    if ({busy, s_ready, err} !== 3'b110) begin
      errors++;
      $display("FAIL len_zero_csum got busy/rdy/err=%b want 110", {busy, s_ready, err});
    end
    send(8'h00, 1'b0, 1'b0);
    check_final("len_zero", 1'b1, 1'b0);
    check_drained("len_zero");
  endtask

  task automatic test_reset_mid_data();
    do_start();
    for (int i = 0; i < 4; i++) send(good_len[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(pl[i], 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_final("mid_reset", 1'b0, 1'b0);
    check_drained("mid_reset");
    do_start();
    send_frame(8'h90, 1'b0);
    check_final("mid_reset_reload", 1'b1, 1'b0);
    check_drained("mid_reset_reload");
  endtask

  initial begin
    pl = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    good_len = '{8'h00, 8'h00, 8'h00, 8'h08};
    test_reset();
    test_nominal();
    test_gapped();
    test_bad_csum();
    test_bad_len();
    test_reset_mid_data();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
